// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared constants, FSM encoding and edge helper for the
// SPI slave. Imported by spi_sync and spi_slave.
package spi_slave_pkg;

    // Frame geometry
    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_CNT_W      = $clog2(SPI_FRAME_BITS + 1);

    // Nominal rates of the target system
    localparam int SPI_CLK_HZ        = 24_000_000;
    localparam int SPI_SCLK_HZ       = 2_400_000;
    localparam int SPI_CLKS_PER_SCLK = SPI_CLK_HZ / SPI_SCLK_HZ;

    // Slave FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } spi_state_e;

    // Trailing edge of sclk: the line leaves its non-idle level and
    // returns to the idle level given by cpol.
    function automatic logic spi_trailing_edge(
        input logic prev,
        input logic cur,
        input logic cpol
    );
        return (prev != cpol) && (cur == cpol);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: single-bit STAGES-deep flop chain for an asynchronous input.
// Ports: clk, reset (sync, active-low), d_i (async in), q_o (synced out).
import spi_slave_pkg::*;

module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // chain_q[0] is the metastability-exposed flop
    if (STAGES > 1) begin : g_multi
        assign chain_d = {chain_q[STAGES-2:0], d_i};
    end else begin : g_single
        assign chain_d = d_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: 16-bit LSB-first SPI slave, single clk domain, trailing-edge
// sampling with synchronized sclk/cs/mosi.
// Ports: clk, reset (sync, active-low); sclk, cs, mosi in; miso out;
//   data_to_tx/tx_load load the reply buffer; data_rx/rx_valid give the
//   received word; frame_err flags an aborted frame; busy marks a frame.
import spi_slave_pkg::*;

module spi_slave #(
    parameter logic CS_ACTIVE   = 1'b0,
    parameter logic CPOL        = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sclk,
    input  logic                      cs,
    input  logic                      mosi,
    output logic                      miso,
    input  logic [SPI_FRAME_BITS-1:0] data_to_tx,
    input  logic                      tx_load,
    output logic [SPI_FRAME_BITS-1:0] data_rx,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int W = SPI_FRAME_BITS;
    localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(W - 1);

    // Synchronized pins
    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    spi_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CPOL)
    ) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .d_i   (sclk),
        .q_o   (sclk_s)
    );

    spi_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (~CS_ACTIVE)
    ) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .d_i   (cs),
        .q_o   (cs_s)
    );

    spi_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .d_i   (mosi),
        .q_o   (mosi_s)
    );

    // State
    spi_state_e           state_q, state_d;
    logic                 sclk_prev_q;
    logic                 cs_prev_q;
    logic [W-1:0]         tx_buf_q, tx_buf_d;
    logic [W-1:0]         tx_shift_q, tx_shift_d;
    logic [W-1:0]         rx_shift_q, rx_shift_d;
    logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]         data_rx_q, data_rx_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 fresh_q, fresh_d;

    // Edge detection on the synchronized copies only
    logic cs_sel;
    logic cs_start;
    logic sample;

    assign cs_sel   = (cs_s == CS_ACTIVE);
    assign cs_start = cs_sel && (cs_prev_q != CS_ACTIVE);
    assign sample   = spi_trailing_edge(sclk_prev_q, sclk_s, CPOL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= ~CS_ACTIVE;
            tx_buf_q    <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            data_rx_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            fresh_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            tx_buf_q    <= tx_buf_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_rx_q   <= data_rx_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            fresh_q     <= fresh_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_buf_d    = tx_buf_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_rx_d   = data_rx_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        fresh_d     = 1'b0;

        // The buffer only feeds the shifter at frame start, so a load
        // mid-frame naturally lands in the next frame.
        if (tx_load) begin
            tx_buf_d = data_to_tx;
        end

        // Publish one cycle after DONE is entered; rx_shift is not
        // touched again until a fresh cs assertion.
        if (fresh_q) begin
            data_rx_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_start) begin
                    state_d    = ST_ACTIVE;
                    tx_shift_d = tx_load ? data_to_tx : tx_buf_q;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_ACTIVE: begin
                if (!cs_sel) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sample) begin
                    rx_shift_d = {mosi_s, rx_shift_q[W-1:1]};
                    tx_shift_d = {1'b0, tx_shift_q[W-1:1]};
                    bit_cnt_d  = bit_cnt_q + SPI_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                        fresh_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Extra sclk edges are ignored until cs releases
                if (!cs_sel) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign miso      = cs_sel ? tx_shift_q[0] : 1'b0;
    assign data_rx   = data_rx_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave
// (CPOL=0, cs active-low, 2-stage sync, 24 MHz clk / 2.4 MHz sclk).
import spi_slave_pkg::*;

module tb_spi_slave;

    localparam int HALF_CLKS = SPI_CLKS_PER_SCLK / 2;
    localparam int SYNC      = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] data_to_tx = '0;
    logic        tx_load = 1'b0;
    logic [15:0] data_rx;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv_cnt   = 0;
    int fe_cnt   = 0;
    int rv_cyc   = 0;
    int fall_cyc = 0;

    logic [15:0] rx;

    spi_slave #(
        .CS_ACTIVE   (1'b0),
        .CPOL        (1'b0),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .data_to_tx (data_to_tx),
        .tx_load    (tx_load),
        .data_rx    (data_rx),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #21 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt = rv_cnt + 1;
            rv_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic check_eq(
        input string       tag,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [15:0] v);
        data_to_tx = v;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        wait_clk(1);
    endtask

    task automatic start_frame();
        rv_cnt = 0;
        fe_cnt = 0;
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic end_frame();
        wait_clk(4);
        cs = 1'b1;
        wait_clk(8);
    endtask

    // Master: drive mosi in low phase, read miso late in high phase,
    // slave samples on the falling edge.
    task automatic send_bits(
        input  logic [15:0] tx,
        input  int          n,
        input  int          load_at,
        input  logic [15:0] load_val,
        output logic [15:0] rxw
    );
        rxw = '0;
        for (int i = 0; i < n; i++) begin
            mosi = (i < 16) ? tx[i[3:0]] : 1'b1;
            if (i == load_at) begin
                data_to_tx = load_val;
                tx_load = 1'b1;
                wait_clk(1);
                tx_load = 1'b0;
                wait_clk(HALF_CLKS - 4);
            end else begin
                wait_clk(HALF_CLKS - 3);
            end
            sclk = 1'b1;
            wait_clk(HALF_CLKS);
            if (i < 16) rxw[i[3:0]] = miso;
            sclk = 1'b0;
            if (i == 15) fall_cyc = cyc;
            wait_clk(3);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_clk(4);
        check_eq("rst data_rx", 32'(data_rx), 32'h0);
        check_eq("rst rx_valid", 32'(rx_valid), 32'h0);
        check_eq("rst frame_err", 32'(frame_err), 32'h0);
        check_eq("rst busy", 32'(busy), 32'h0);
        check_eq("rst miso", 32'(miso), 32'h0);
        reset = 1'b1;
        wait_clk(4);

        // Basic frame
        load_tx(16'hA55A);
        start_frame();
        send_bits(16'h1234, 16, -1, 16'h0, rx);
        check_eq("f1 busy", 32'(busy), 32'h1);
        end_frame();
        check_eq("f1 data_rx", 32'(data_rx), 32'h1234);
        check_eq("f1 rv_cnt", 32'(rv_cnt), 32'd1);
        check_eq("f1 miso word", 32'(rx), 32'hA55A);
        check_eq("f1 latency", 32'(rv_cyc - fall_cyc), 32'(SYNC + 2));
        check_eq("f1 fe_cnt", 32'(fe_cnt), 32'd0);
        check_eq("f1 busy end", 32'(busy), 32'h0);
        check_eq("f1 miso idle", 32'(miso), 32'h0);

        // Back-to-back, buffer resent
        start_frame();
        send_bits(16'h0001, 16, -1, 16'h0, rx);
        end_frame();
        check_eq("b1 data_rx", 32'(data_rx), 32'h0001);
        check_eq("b1 rv_cnt", 32'(rv_cnt), 32'd1);
        check_eq("b1 miso word", 32'(rx), 32'hA55A);
        start_frame();
        send_bits(16'h8000, 16, -1, 16'h0, rx);
        end_frame();
        check_eq("b2 data_rx", 32'(data_rx), 32'h8000);
        check_eq("b2 rv_cnt", 32'(rv_cnt), 32'd1);
        check_eq("b2 miso word", 32'(rx), 32'hA55A);

        // Abort after 7 edges
        start_frame();
        send_bits(16'h7777, 7, -1, 16'h0, rx);
        end_frame();
        check_eq("ab fe_cnt", 32'(fe_cnt), 32'd1);
        check_eq("ab rv_cnt", 32'(rv_cnt), 32'd0);
        check_eq("ab data_rx", 32'(data_rx), 32'h8000);
        check_eq("ab busy", 32'(busy), 32'h0);

        // tx_load mid-frame affects only the next frame
        load_tx(16'h0F0F);
        start_frame();
        send_bits(16'h5A5A, 16, 5, 16'hFFFF, rx);
        end_frame();
        check_eq("ml cur word", 32'(rx), 32'h0F0F);
        check_eq("ml data_rx", 32'(data_rx), 32'h5A5A);
        start_frame();
        send_bits(16'h0000, 16, -1, 16'h0, rx);
        end_frame();
        check_eq("ml next word", 32'(rx), 32'hFFFF);

        // Reset mid-frame
        start_frame();
        send_bits(16'h1111, 9, -1, 16'h0, rx);
        reset = 1'b0;
        wait_clk(2);
        cs = 1'b1;
        wait_clk(4);
        check_eq("rm rv_cnt", 32'(rv_cnt), 32'd0);
        check_eq("rm fe_cnt", 32'(fe_cnt), 32'd0);
        check_eq("rm data_rx", 32'(data_rx), 32'h0);
        check_eq("rm busy", 32'(busy), 32'h0);
        reset = 1'b1;
        wait_clk(4);
        start_frame();
        send_bits(16'hBEEF, 16, -1, 16'h0, rx);
        end_frame();
        check_eq("rm2 data_rx", 32'(data_rx), 32'hBEEF);
        check_eq("rm2 rv_cnt", 32'(rv_cnt), 32'd1);
        check_eq("rm2 fe_cnt", 32'(fe_cnt), 32'd0);
        check_eq("rm2 tx cleared", 32'(rx), 32'h0);

        // 20 edges in one cs window
        load_tx(16'h1357);
        start_frame();
        send_bits(16'hC3A5, 20, -1, 16'h0, rx);
        check_eq("ov busy", 32'(busy), 32'h1);
        end_frame();
        check_eq("ov rv_cnt", 32'(rv_cnt), 32'd1);
        check_eq("ov data_rx", 32'(data_rx), 32'hC3A5);
        check_eq("ov miso word", 32'(rx), 32'h1357);
        check_eq("ov fe_cnt", 32'(fe_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
